cache_trace_driver: RTL and testbench
=====================================

# cache_trace_driver

Trace-driven initiator for the direct-mapped cache's access port. It holds a loadable table of access descriptors, issues them to the cache one at a time, and checks each registered response (hit/miss flag, data) against the descriptor's expectations. It also checks the cache's running access and miss counters at the end of the run. It sits beside the cache in the simulation/FPGA self-test harness and gives a single pass/fail verdict with mismatch diagnostics.

## Interface
- TRACE_DEPTH, 64: number of descriptor entries (power of two)
- IDX_W, 6: log2(TRACE_DEPTH)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse; begins a run when idle
- trace_len  in  IDX_W+1  number of entries to run; sampled on start
- load_we  in  1  write one descriptor into the table
- load_idx  in  IDX_W  descriptor slot
- load_entry  in  67  {we[66], chk_data[65], exp_hit[64], addr[63:32], data[31:0]}
- access  out  1  cache access strobe
- Address  out  32  cache address
- Write_Data  out  32  cache write data
- Write_Enable  out  1  cache write select
- Data_Out  in  32  cache data response (registered in cache)
- Hit_Miss  in  1  cache hit flag (1 = hit)
- total_accesses  in  32  cache access counter
- total_misses  in  32  cache miss counter
- busy  out  1  run in progress
- done  out  1  run finished; held until next accepted start or reset
- pass  out  1  valid while done; 1 = zero mismatches and counter check good
- mismatch_count  out  16  per-entry mismatches, saturating at 0xFFFF
- miss_count  out  16  observed Hit_Miss==0 responses, saturating
- first_fail_idx  out  IDX_W+1  index of first failing entry; all-ones if none; TRACE_DEPTH if only the final counter check failed

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, FINAL, DONE.
- IDLE/DONE with start=1: latch len = min(trace_len, TRACE_DEPTH), snapshot base_acc=total_accesses and base_miss=total_misses, clear mismatch_count, miss_count, done, and pass, set first_fail_idx all-ones and ptr=0. Then go to ISSUE, or to FINAL if len==0.
- ISSUE: access=1 and drive Address, Write_Data, Write_Enable from entry[ptr]. Go to CAPTURE.
- CAPTURE: access=0. Compare Hit_Miss to exp_hit. If chk_data=1, also compare Data_Out to data; this applies to writes too, because the cache echoes Write_Data on writes. Any difference counts as one mismatch for the entry. On the first mismatch, record ptr. If Hit_Miss==0, increment miss_count. Then ptr+1: go to ISSUE if ptr+1<len, else FINAL.
- FINAL: counter check. Require (total_accesses − base_acc) mod 2^32 == len and (total_misses − base_miss) mod 2^32 == miss_count (zero-extended). On failure, add one mismatch and set first_fail_idx=TRACE_DEPTH if it is still all-ones. Go to DONE.
- DONE: done=1, busy=0, pass=(mismatch_count==0).
- busy=1 in ISSUE, CAPTURE, and FINAL.
- start while busy: ignored. load_we while busy: ignored. load_we while idle: the table write takes effect next cycle. The table is not cleared by reset.
- Address, Write_Data, and Write_Enable hold their last values when access=0.

## Timing
- Reset values: access 0, Address 0, Write_Data 0, Write_Enable 0, busy 0, done 0, pass 0, mismatch_count 0, miss_count 0, first_fail_idx all-ones, state IDLE.
- All outputs are registered.
- Cache contract: access sampled at edge E. Data_Out, Hit_Miss, and counters are valid after E and sampled by this block at edge E+1, the end of CAPTURE.
- Each entry takes 2 cycles, and access is never high on consecutive cycles.
- A run of N entries: start at edge S gives done=1 after edge S+2N+2.
- len==0: done after edge S+2.
- Reset mid-run: access drops to 0 at the reset edge, the FSM returns to IDLE, and all statistics clear. The cache sees at most the one access already issued.
- start coincident with load_we in IDLE: both accepted. The run's first ISSUE reads the table after the load commits.

## Test plan
- Reset cache and driver, then load 4 entries: read 0x00, read 0x04, read 0x100, read 0x00, exp_hit 0,1,0,0 (0x100 evicts index 0), chk_data on with memory-image values; start, trace_len=4 -> 4 access pulses 2 cycles apart; done after 10 cycles; pass=1, miss_count=3, mismatch_count=0, first_fail_idx=all-ones.
- Write 0xDEADBEEF to 0x08 (exp_hit 0), then read 0x08 with data=0xDEADBEEF, exp_hit 1 -> pass=1, miss_count=1.
- Same trace but entry 1 expects data 0x12345678 -> pass=0, mismatch_count=1, first_fail_idx=1.
- trace_len=0 -> done 2 cycles after start, access never asserted, pass=1. trace_len=100 with TRACE_DEPTH=64 -> exactly 64 accesses issued.
- Assert reset during CAPTURE of entry 2 -> access=0, busy=0, done=0 next cycle; a fresh start reruns from entry 0. start pulsed mid-run -> ignored, access count unchanged.
- Force the cache's total_misses input +1 during FINAL (bench override) -> pass=0, first_fail_idx=TRACE_DEPTH.

Source files
------------

// File: rtl/cache_trace_driver.sv
// Trace-driven initiator for the direct-mapped cache access port: replays a
// loadable descriptor table, checks each response and the cache counters.
module cache_trace_driver #(
  parameter int unsigned TRACE_DEPTH = 64,
  parameter int unsigned IDX_W       = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [IDX_W:0]     trace_len,
  input  logic               load_we,
  input  logic [IDX_W-1:0]   load_idx,
  input  logic [66:0]        load_entry,
  output logic               access,
  output logic [31:0]        Address,
  output logic [31:0]        Write_Data,
  output logic               Write_Enable,
  input  logic [31:0]        Data_Out,
  input  logic               Hit_Miss,
  input  logic [31:0]        total_accesses,
  input  logic [31:0]        total_misses,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [15:0]        mismatch_count,
  output logic [15:0]        miss_count,
  output logic [IDX_W:0]     first_fail_idx
);

  localparam int unsigned LEN_W = IDX_W + 1;
  localparam logic [LEN_W-1:0] NO_FAIL = '1;
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(TRACE_DEPTH);

  typedef struct packed {
    logic        we;
    logic        chk_data;
    logic        exp_hit;
    logic [31:0] addr;
    logic [31:0] data;
  } entry_t;

  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, FINAL, DONE} state_t;

  state_t             state_q, state_d;
  entry_t             table_mem [TRACE_DEPTH];
  logic [LEN_W-1:0]   ptr_q, ptr_d, len_q, len_d, start_len;
  logic [31:0]        base_acc_q, base_acc_d, base_miss_q, base_miss_d;
  logic [31:0]        acc_delta, miss_delta;
  logic [15:0]        mismatch_d, miss_d;
  logic [LEN_W-1:0]   first_fail_d;
  logic               access_d, we_d, busy_d, done_d, pass_d;
  logic [31:0]        address_d, wdata_d;
  logic               idle, issue, bypass, cnt_ok;
  logic [IDX_W-1:0]   cap_idx, iss_idx;
  logic               cap_exp_hit, cap_chk, entry_bad;
  logic [31:0]        cap_data;

  assign idle       = (state_q == IDLE) || (state_q == DONE);
  assign start_len  = (trace_len > DEPTH_L) ? DEPTH_L : trace_len;
  assign acc_delta  = total_accesses - base_acc_q;
  assign miss_delta = total_misses - base_miss_q;
  assign cnt_ok     = (acc_delta == 32'(len_q)) && (miss_delta == 32'(miss_count));

  // Response check for the entry currently in CAPTURE
  assign cap_idx     = ptr_q[IDX_W-1:0];
  assign cap_exp_hit = table_mem[cap_idx].exp_hit;
  assign cap_chk     = table_mem[cap_idx].chk_data;
  assign cap_data    = table_mem[cap_idx].data;
  assign entry_bad   = (Hit_Miss != cap_exp_hit) || (cap_chk && (Data_Out != cap_data));

  // Table is only writable while idle and deliberately has no reset
  always_ff @(posedge clk) begin
    if (load_we && idle) table_mem[load_idx] <= entry_t'(load_entry);
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    len_d        = len_q;
    base_acc_d   = base_acc_q;
    base_miss_d  = base_miss_q;
    mismatch_d   = mismatch_count;
    miss_d       = miss_count;
    first_fail_d = first_fail_idx;
    access_d     = 1'b0;
    address_d    = Address;
    wdata_d      = Write_Data;
    we_d         = Write_Enable;
    busy_d       = busy;
    done_d       = done;
    pass_d       = pass;
    issue        = 1'b0;
    iss_idx      = '0;
    bypass       = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) begin
          done_d = 1'b1;
          pass_d = (mismatch_count == 16'd0);
        end
        if (start) begin
          len_d        = start_len;
          base_acc_d   = total_accesses;
          base_miss_d  = total_misses;
          mismatch_d   = '0;
          miss_d       = '0;
          first_fail_d = NO_FAIL;
          ptr_d        = '0;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          busy_d       = 1'b1;
          if (start_len == '0) begin
            state_d = FINAL;
          end else begin
            state_d = ISSUE;
            issue   = 1'b1;
          end
        end
      end
      ISSUE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        if (entry_bad) begin
          mismatch_d = (mismatch_count == 16'hFFFF) ? mismatch_count : mismatch_count + 16'd1;
          if (first_fail_idx == NO_FAIL) first_fail_d = ptr_q;
        end
        if (!Hit_Miss) miss_d = (miss_count == 16'hFFFF) ? miss_count : miss_count + 16'd1;
        ptr_d = ptr_q + LEN_W'(1);
        if (ptr_d < len_q) begin
          state_d = ISSUE;
          issue   = 1'b1;
        end else begin
          state_d = FINAL;
        end
      end
      FINAL: begin
        if (!cnt_ok) begin
          mismatch_d = (mismatch_count == 16'hFFFF) ? mismatch_count : mismatch_count + 16'd1;
          if (first_fail_idx == NO_FAIL) first_fail_d = DEPTH_L;
        end
        busy_d  = 1'b0;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    // Registered access is high during ISSUE; a same-edge table load is forwarded
    if (issue) begin
      iss_idx   = ptr_d[IDX_W-1:0];
      bypass    = load_we && idle && (load_idx == iss_idx);
      access_d  = 1'b1;
      address_d = bypass ? load_entry[63:32] : table_mem[iss_idx].addr;
      wdata_d   = bypass ? load_entry[31:0]  : table_mem[iss_idx].data;
      we_d      = bypass ? load_entry[66]    : table_mem[iss_idx].we;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      len_q          <= '0;
      base_acc_q     <= '0;
      base_miss_q    <= '0;
      mismatch_count <= '0;
      miss_count     <= '0;
      first_fail_idx <= NO_FAIL;
      access         <= 1'b0;
      Address        <= '0;
      Write_Data     <= '0;
      Write_Enable   <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      len_q          <= len_d;
      base_acc_q     <= base_acc_d;
      base_miss_q    <= base_miss_d;
      mismatch_count <= mismatch_d;
      miss_count     <= miss_d;
      first_fail_idx <= first_fail_d;
      access         <= access_d;
      Address        <= address_d;
      Write_Data     <= wdata_d;
      Write_Enable   <= we_d;
      busy           <= busy_d;
      done           <= done_d;
      pass           <= pass_d;
    end
  end

endmodule

// File: tb/tb_cache_trace_driver.sv
// Directed bench for cache_trace_driver with a small behavioural direct-mapped
// cache (16 lines x 16 bytes, write-allocate, echoes write data).
module tb_cache_trace_driver;

  logic        clk = 1'b0;
  logic        reset, start, load_we;
  logic [6:0]  trace_len;
  logic [5:0]  load_idx;
  logic [66:0] load_entry;
  logic        access, Write_Enable, busy, done, pass;
  logic [31:0] Address, Write_Data, Data_Out, total_accesses, total_misses;
  logic        Hit_Miss;
  logic [15:0] mismatch_count, miss_count;
  logic [6:0]  first_fail_idx;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  cache_trace_driver dut (
    .clk(clk), .reset(reset), .start(start), .trace_len(trace_len),
    .load_we(load_we), .load_idx(load_idx), .load_entry(load_entry),
    .access(access), .Address(Address), .Write_Data(Write_Data),
    .Write_Enable(Write_Enable), .Data_Out(Data_Out), .Hit_Miss(Hit_Miss),
    .total_accesses(total_accesses), .total_misses(total_misses),
    .busy(busy), .done(done), .pass(pass), .mismatch_count(mismatch_count),
    .miss_count(miss_count), .first_fail_idx(first_fail_idx)
  );

  // Behavioural cache
  logic [15:0]   c_valid;
  logic [23:0]   c_tag [16];
  logic [31:0]   wmem [4096];
  logic [4095:0] wvalid;
  logic [31:0]   c_acc, c_miss;
  logic          miss_bias;
  logic [3:0]    c_idx;
  logic [11:0]   c_widx;
  logic          c_hit;

  assign c_idx  = Address[7:4];
  assign c_widx = Address[13:2];
  assign c_hit  = c_valid[c_idx] && (c_tag[c_idx] == Address[31:8]);
  assign total_accesses = c_acc;
  assign total_misses   = c_miss + 32'(miss_bias);

  always @(posedge clk) begin
    if (reset) begin
      c_valid  <= '0;
      wvalid   <= '0;
      c_acc    <= '0;
      c_miss   <= '0;
      Hit_Miss <= 1'b0;
      Data_Out <= '0;
    end else if (access) begin
      Hit_Miss      <= c_hit;
      c_acc         <= c_acc + 32'd1;
      if (!c_hit) c_miss <= c_miss + 32'd1;
      c_valid[c_idx] <= 1'b1;
      c_tag[c_idx]   <= Address[31:8];
      if (Write_Enable) begin
        wmem[c_widx]   <= Write_Data;
        wvalid[c_widx] <= 1'b1;
        Data_Out       <= Write_Data;
      end else begin
        Data_Out <= wvalid[c_widx] ? wmem[c_widx] : (Address ^ 32'hA5A5_0000);
      end
    end
  end

  // Access pulse monitor: total pulses and back-to-back occurrences
  int   pulses = 0;
  int   b2b    = 0;
  logic prev_access = 1'b0;
  always @(posedge clk) begin
    prev_access <= access;
    if (access) pulses <= pulses + 1;
    if (access && prev_access) b2b <= b2b + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [66:0] mk(input logic we, input logic chk, input logic hit,
                                     input logic [31:0] addr, input logic [31:0] data);
    return {we, chk, hit, addr, data};
  endfunction

  task automatic load(input int idx, input logic [66:0] e);
    load_we    = 1'b1;
    load_idx   = 6'(idx);
    load_entry = e;
    tick();
    load_we = 1'b0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    miss_bias = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic load_basic();
    load(0, mk(1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'hA5A5_0000));
    load(1, mk(1'b0, 1'b1, 1'b1, 32'h0000_0004, 32'hA5A5_0004));
    load(2, mk(1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'hA5A5_0100));
    load(3, mk(1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'hA5A5_0000));
  endtask

  // Pulses start, then waits (bounded) for done; lat counts edges after the start edge
  task automatic run_trace(input logic [6:0] len, input int glitch_at, input int bias_at,
                           output int lat, output int npulse, output int nb2b);
    int p0, b0;
    p0 = pulses;
    b0 = b2b;
    trace_len = len;
    start = 1'b1;
    tick();
    start   = 1'b0;
    load_we = 1'b0;
    lat = 0;
    while (!done && lat < 400) begin
      start = (lat == glitch_at);
      if (lat == bias_at) miss_bias = 1'b1;
      tick();
      lat++;
    end
    start  = 1'b0;
    npulse = pulses - p0;
    nb2b   = b2b - b0;
  endtask

  initial begin
    int lat, np, nb, p0;
    start = 1'b0; load_we = 1'b0; load_idx = '0; load_entry = '0;
    trace_len = '0; miss_bias = 1'b0; reset = 1'b0;

    do_reset();
    check("rst_access", 32'(access), 32'd0);
    check("rst_addr", Address, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_ffi", 32'(first_fail_idx), 32'h7F);
    check("rst_mism", 32'(mismatch_count), 32'd0);

    // Basic read trace with an eviction
    load_basic();
    run_trace(7'd4, -1, -1, lat, np, nb);
    check("t1_lat", 32'(lat), 32'd10);
    check("t1_pulses", 32'(np), 32'd4);
    check("t1_b2b", 32'(nb), 32'd0);
    check("t1_pass", 32'(pass), 32'd1);
    check("t1_miss", 32'(miss_count), 32'd3);
    check("t1_mism", 32'(mismatch_count), 32'd0);
    check("t1_ffi", 32'(first_fail_idx), 32'h7F);

    // Write then read back; slot 0 loaded on the same edge as start
    do_reset();
    load(1, mk(1'b0, 1'b1, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF));
    load_we = 1'b1; load_idx = 6'd0;
    load_entry = mk(1'b1, 1'b1, 1'b0, 32'h0000_0008, 32'hDEAD_BEEF);
    run_trace(7'd2, -1, -1, lat, np, nb);
    check("t2_lat", 32'(lat), 32'd6);
    check("t2_pass", 32'(pass), 32'd1);
    check("t2_miss", 32'(miss_count), 32'd1);
    check("t2_we_hold", 32'(Write_Enable), 32'd0);

    // Wrong expected data on entry 1
    do_reset();
    load(1, mk(1'b0, 1'b1, 1'b1, 32'h0000_0008, 32'h1234_5678));
    run_trace(7'd2, -1, -1, lat, np, nb);
    check("t3_pass", 32'(pass), 32'd0);
    check("t3_mism", 32'(mismatch_count), 32'd1);
    check("t3_ffi", 32'(first_fail_idx), 32'd1);

    // Empty run
    do_reset();
    run_trace(7'd0, -1, -1, lat, np, nb);
    check("t4_lat", 32'(lat), 32'd2);
    check("t4_pulses", 32'(np), 32'd0);
    check("t4_pass", 32'(pass), 32'd1);

    // Over-long trace_len clamps to 64 entries
    do_reset();
    for (int i = 0; i < 64; i++) load(i, mk(1'b0, 1'b0, 1'b0, 32'(i) << 8, 32'd0));
    run_trace(7'd100, -1, -1, lat, np, nb);
    check("t5_pulses", 32'(np), 32'd64);
    check("t5_lat", 32'(lat), 32'd130);
    check("t5_miss", 32'(miss_count), 32'd64);
    check("t5_pass", 32'(pass), 32'd1);
    check("t5_b2b", 32'(nb), 32'd0);
    check("t5_addr_hold", Address, 32'h0000_3F00);

    // Reset during CAPTURE of entry 2
    do_reset();
    load_basic();
    p0 = pulses;
    trace_len = 7'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_access", 32'(access), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    check("t6_miss", 32'(miss_count), 32'd0);
    check("t6_pulses", 32'(pulses - p0), 32'd3);

    // Fresh rerun with a start pulse mid-run
    run_trace(7'd4, 3, -1, lat, np, nb);
    check("t6r_lat", 32'(lat), 32'd10);
    check("t6r_pulses", 32'(np), 32'd4);
    check("t6r_pass", 32'(pass), 32'd1);
    check("t6r_miss", 32'(miss_count), 32'd3);

    // Miss counter bumped during FINAL
    do_reset();
    run_trace(7'd4, -1, 8, lat, np, nb);
    check("t7_pass", 32'(pass), 32'd0);
    check("t7_ffi", 32'(first_fail_idx), 32'd64);
    check("t7_mism", 32'(mismatch_count), 32'd1);
    check("t7_miss", 32'(miss_count), 32'd3);
    miss_bias = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
